// File: rtl/data_mem_arbiter.sv
// Data memory port arbiter between the pipeline MEM stage (core) and a debug/loader host.
// Core wins by default; debug takes idle slots, a starvation-forced slot, or the whole port while halted.
module data_mem_arbiter #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_rvalid,
   input  logic              dbg_halt_req,
   output logic              dbg_halt_ack,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [0:0]        state_reg, state_next;
   logic [3:0]        wait_cnt_reg, wait_cnt_next;
   logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;
   logic              dbg_rvalid_reg, dbg_rvalid_next;

   logic halted;
   logic forced_slot;
   logic core_owns;
   logic dbg_owns;

   // Ownership is decided fresh every cycle; nobody owns the port while reset is held.
   always_comb begin
      halted      = (state_reg == ST_HALT);
      forced_slot = !halted && core_req && dbg_req && (wait_cnt_reg == MAX_WAIT_C);
      core_owns   = 1'b0;
      dbg_owns    = 1'b0;
      if (rst_n) begin
         if (halted) begin
            dbg_owns = dbg_req;
         end else if (forced_slot) begin
            dbg_owns = 1'b1;
         end else if (core_req) begin
            core_owns = 1'b1;
         end else begin
            dbg_owns = dbg_req;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_mux
         assign mem_read_addr[gi]  = (core_owns & core_addr[gi]) | (dbg_owns & dbg_addr[gi]);
         assign mem_write_addr[gi] = (core_owns & core_addr[gi]) | (dbg_owns & dbg_addr[gi]);
      end
      for (gi = 0; gi < DATA_W; gi++) begin : g_data_mux
         assign mem_write_data[gi] = (core_owns & core_wdata[gi]) | (dbg_owns & dbg_wdata[gi]);
      end
   endgenerate

   assign mem_write_enable = (core_owns & core_we) | (dbg_owns & dbg_we);
   assign dbg_gnt          = dbg_owns;
   assign core_stall       = rst_n & (halted ? core_req : forced_slot);
   assign dbg_halt_ack     = rst_n & halted;
   assign core_rdata       = mem_read_data;
   assign dbg_rdata        = dbg_rdata_reg;
   assign dbg_rvalid       = dbg_rvalid_reg;

   always_comb begin
      state_next      = state_reg;
      wait_cnt_next   = 4'd0;
      dbg_rdata_next  = dbg_rdata_reg;
      dbg_rvalid_next = 1'b0;

      // Halt is only entered on a cycle with no core access in flight.
      if (halted) begin
         if (!dbg_halt_req) state_next = ST_RUN;
      end else if (dbg_halt_req && !core_req) begin
         state_next = ST_HALT;
      end

      if (!halted && dbg_req && !dbg_owns) begin
         wait_cnt_next = (wait_cnt_reg == MAX_WAIT_C) ? wait_cnt_reg : wait_cnt_reg + 4'd1;
      end

      if (dbg_owns && !dbg_we) begin
         dbg_rdata_next  = mem_read_data;
         dbg_rvalid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= ST_RUN;
         wait_cnt_reg   <= 4'd0;
         dbg_rdata_reg  <= '0;
         dbg_rvalid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wait_cnt_reg   <= wait_cnt_next;
         dbg_rdata_reg  <= dbg_rdata_next;
         dbg_rvalid_reg <= dbg_rvalid_next;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a cycle-level model of the sharing rules checked every cycle,
// plus directed literal expectations along the test plan.
module tb_data_mem_arbiter;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 5;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              rst_n;
   logic              core_req, core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata, core_rdata;
   logic              core_stall;
   logic              dbg_req, dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
   logic              dbg_gnt, dbg_rvalid;
   logic              dbg_halt_req, dbg_halt_ack;
   logic              mem_write_enable;
   logic [ADDR_W-1:0] mem_read_addr, mem_write_addr;
   logic [DATA_W-1:0] mem_write_data, mem_read_data;

   data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .dbg_halt_req(dbg_halt_req), .dbg_halt_ack(dbg_halt_ack),
      .mem_write_enable(mem_write_enable), .mem_read_addr(mem_read_addr),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DataMem stand-in: combinational read, write at the clock edge.
   logic [DATA_W-1:0] dmem [32];
   assign mem_read_data = dmem[mem_read_addr];
   always @(posedge clk) if (mem_write_enable) dmem[mem_write_addr] <= mem_write_data;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model state: halt flag, refused-cycle count, last debug read, its own copy of memory.
   bit              m_halt = 0;
   int              m_wait = 0;
   bit              m_rvalid = 0;
   logic [DATA_W-1:0] m_rdata = '0;
   logic [DATA_W-1:0] m_mem [32];
   bit              n_halt, n_rvalid, n_wen;
   int              n_wait;
   logic [DATA_W-1:0] n_rdata, n_wdata;
   logic [ADDR_W-1:0] n_waddr;

   initial begin
      for (int i = 0; i < 32; i++) begin
         dmem[i]  = '0;
         m_mem[i] = '0;
      end
   end

   always @(negedge clk) begin
      int owner;   // 0 none, 1 core, 2 debug
      bit e_stall, e_ack, e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      owner = 0; e_stall = 0; e_ack = 0;
      if (rst_n) begin
         if (m_halt) begin
            e_ack = 1; e_stall = core_req;
            if (dbg_req) owner = 2;
         end else if (core_req && dbg_req && m_wait == MAX_WAIT) begin
            owner = 2; e_stall = 1;
         end else if (core_req) owner = 1;
         else if (dbg_req) owner = 2;
      end
      e_addr  = (owner == 1) ? core_addr  : (owner == 2) ? dbg_addr  : '0;
      e_wdata = (owner == 1) ? core_wdata : (owner == 2) ? dbg_wdata : '0;
      e_we    = (owner == 1) ? core_we    : (owner == 2) ? dbg_we    : 1'b0;

      chk("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
      chk("mem_read_addr",    32'(mem_read_addr),    32'(e_addr));
      chk("mem_write_addr",   32'(mem_write_addr),   32'(e_addr));
      chk("mem_write_data",   32'(mem_write_data),   32'(e_wdata));
      chk("dbg_gnt",          32'(dbg_gnt),          32'(owner == 2));
      chk("core_stall",       32'(core_stall),       32'(e_stall));
      chk("dbg_halt_ack",     32'(dbg_halt_ack),     32'(e_ack));
      chk("dbg_rvalid",       32'(dbg_rvalid),       32'(m_rvalid));
      chk("dbg_rdata",        32'(dbg_rdata),        32'(m_rdata));
      if (owner == 1 && !core_we) chk("core_rdata", 32'(core_rdata), 32'(m_mem[core_addr]));

      n_wen = 0; n_waddr = e_addr; n_wdata = e_wdata;
      if (!rst_n) begin
         n_halt = 0; n_wait = 0; n_rvalid = 0; n_rdata = '0;
      end else begin
         n_wen    = e_we;
         n_rvalid = (owner == 2) && !dbg_we;
         n_rdata  = n_rvalid ? m_mem[dbg_addr] : m_rdata;
         if (m_halt) n_wait = 0;
         else if (dbg_req && owner != 2) n_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
         else n_wait = 0;
         n_halt = m_halt ? dbg_halt_req : (dbg_halt_req && !core_req);
      end
   end

   always @(posedge clk) begin
      m_halt = n_halt; m_wait = n_wait; m_rvalid = n_rvalid; m_rdata = n_rdata;
      if (n_wen) m_mem[n_waddr] = n_wdata;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt_req = 0;
      // Model starts idle; keep it idle until the first reset edge has passed.
      n_halt = 0; n_wait = 0; n_rvalid = 0; n_rdata = '0; n_wen = 0; n_waddr = '0; n_wdata = '0;
      cyc(); cyc();
      mid();
      chk("reset_rvalid", 32'(dbg_rvalid), 32'd0);
      chk("reset_rdata",  32'(dbg_rdata),  32'd0);
      chk("reset_ack",    32'(dbg_halt_ack), 32'd0);
      cyc();
      rst_n = 1;

      // Core store of 0x5A to address 3
      core_req = 1; core_we = 1; core_addr = 5'd3; core_wdata = 8'h5A;
      mid();
      chk("t1_we",    32'(mem_write_enable), 32'd1);
      chk("t1_waddr", 32'(mem_write_addr),   32'd3);
      chk("t1_wdata", 32'(mem_write_data),   32'h5A);
      chk("t1_stall", 32'(core_stall),       32'd0);
      chk("t1_gnt",   32'(dbg_gnt),          32'd0);
      cyc();

      // Debug read of address 3 in an idle slot
      core_req = 0; core_we = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd3;
      mid();
      chk("t2_gnt", 32'(dbg_gnt), 32'd1);
      cyc();
      dbg_req = 0;
      mid();
      chk("t2_rvalid", 32'(dbg_rvalid), 32'd1);
      chk("t2_rdata",  32'(dbg_rdata),  32'h5A);
      cyc();
      core_req = 1; core_we = 0; core_addr = 5'd3;
      mid();
      chk("t2_rvalid_drop", 32'(dbg_rvalid), 32'd0);
      chk("t2_core_rdata",  32'(core_rdata), 32'h5A);
      cyc();

      // Starved debug write forces a slot after MAX_WAIT refusals
      core_we = 1; core_addr = 5'd2; core_wdata = 8'hEE;
      dbg_req = 1; dbg_we = 1; dbg_addr = 5'd7; dbg_wdata = 8'h11;
      for (int i = 0; i < MAX_WAIT; i++) begin
         mid();
         chk("t3_refused_gnt",   32'(dbg_gnt),        32'd0);
         chk("t3_refused_waddr", 32'(mem_write_addr), 32'd2);
         cyc();
      end
      mid();
      chk("t3_forced_gnt",   32'(dbg_gnt),          32'd1);
      chk("t3_forced_stall", 32'(core_stall),       32'd1);
      chk("t3_forced_waddr", 32'(mem_write_addr),   32'd7);
      chk("t3_forced_wdata", 32'(mem_write_data),   32'h11);
      chk("t3_forced_we",    32'(mem_write_enable), 32'd1);
      cyc();
      dbg_req = 0;
      mid();
      chk("t3_after_stall", 32'(core_stall),     32'd0);
      chk("t3_after_waddr", 32'(mem_write_addr), 32'd2);
      cyc();
      core_req = 0; core_we = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 5'd7;
      cyc();
      dbg_req = 0;
      mid();
      chk("t3_readback", 32'(dbg_rdata), 32'h11);
      cyc();

      // Halt request waits for the core to go quiet
      core_req = 1; core_we = 0; core_addr = 5'd2; dbg_halt_req = 1;
      mid(); chk("t4_ack_wait0", 32'(dbg_halt_ack), 32'd0); cyc();
      mid(); chk("t4_ack_wait1", 32'(dbg_halt_ack), 32'd0); cyc();
      core_req = 0;
      mid(); chk("t4_ack_wait2", 32'(dbg_halt_ack), 32'd0); cyc();
      mid(); chk("t4_ack", 32'(dbg_halt_ack), 32'd1);
      core_req = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd3;
      #1;
      chk("t4_halt_stall", 32'(core_stall), 32'd1);
      chk("t4_halt_gnt0",  32'(dbg_gnt),    32'd1);
      cyc();
      dbg_addr = 5'd7;
      mid();
      chk("t4_halt_gnt1", 32'(dbg_gnt),   32'd1);
      chk("t4_rdata0",    32'(dbg_rdata), 32'h5A);
      cyc();
      dbg_req = 0;
      mid();
      chk("t4_rdata1", 32'(dbg_rdata), 32'h11);

      // Leaving halt
      dbg_halt_req = 0;
      #1;
      chk("t5_ack_still", 32'(dbg_halt_ack), 32'd1);
      chk("t5_stall_still", 32'(core_stall), 32'd1);
      cyc();
      mid();
      chk("t5_ack_drop", 32'(dbg_halt_ack), 32'd0);
      chk("t5_core_runs", 32'(core_stall), 32'd0);
      cyc();

      // Reset during halt with a debug read pending
      core_req = 0; dbg_halt_req = 1;
      cyc();
      mid(); chk("t6_ack", 32'(dbg_halt_ack), 32'd1);
      cyc();
      rst_n = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 5'd7; core_req = 1;
      mid();
      chk("t6_rst_gnt",   32'(dbg_gnt),          32'd0);
      chk("t6_rst_ack",   32'(dbg_halt_ack),     32'd0);
      chk("t6_rst_we",    32'(mem_write_enable), 32'd0);
      chk("t6_rst_stall", 32'(core_stall),       32'd0);
      chk("t6_rst_raddr", 32'(mem_read_addr),    32'd0);
      cyc();
      rst_n = 1; dbg_halt_req = 0;
      for (int i = 0; i < MAX_WAIT; i++) begin
         mid();
         chk("t6_refused_gnt", 32'(dbg_gnt), 32'd0);
         if (i == 0) begin
            chk("t6_post_rvalid", 32'(dbg_rvalid), 32'd0);
            chk("t6_post_rdata",  32'(dbg_rdata),  32'd0);
            chk("t6_post_ack",    32'(dbg_halt_ack), 32'd0);
         end
         cyc();
      end
      mid();
      chk("t6_forced_gnt", 32'(dbg_gnt), 32'd1);
      cyc();
      dbg_req = 0; core_req = 0;
      mid();
      chk("t6_forced_rdata", 32'(dbg_rdata), 32'h11);
      cyc(); cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
